cmp8_window_stats: RTL
======================

Name: cmp8_window_stats

Overview:
Downstream consumer of the 8-bit comparator's GREATER/LESS flags. Classifies each valid compare result as greater, less, equal or illegal, and accumulates counts over a fixed window of WINDOW samples. At the end of each window it presents the counts and a majority verdict on a valid/ready output handshake. Used to summarise comparator activity, for example for sweep-based checking or to drive trend indicators.

Parameters:
WINDOW, 16, number of accepted samples per window; legal range 2..255.
CNT_W, 8, width of each count output; counters saturate at 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous abort; discards the current window and any held result.
in_valid  input  1  GREATER/LESS carry a sample this cycle.
in_ready  output  1  block can accept a sample.
GREATER  input  1  comparator a>b flag.
LESS  input  1  comparator a<b flag.
out_valid  output  1  window result is held on the outputs.
out_ready  input  1  consumer accepts the result.
gt_cnt  output  CNT_W  count of samples with GREATER=1, LESS=0.
lt_cnt  output  CNT_W  count of samples with GREATER=0, LESS=1.
eq_cnt  output  CNT_W  count of samples with GREATER=0, LESS=0.
err_cnt  output  CNT_W  count of illegal samples with GREATER=1, LESS=1.
majority  output  2  01 if gt>lt; 10 if lt>gt; 00 if gt==lt. Eq and err counts are ignored.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. While rst=1:
  - state=ACCUM, all internal counters and the sample index are 0.
  - out_valid=0; gt/lt/eq/err_cnt=0; majority=00; in_ready=1 on the first cycle after release.
- A sample is accepted on a rising edge when in_valid & in_ready.
- FSM state ACCUM:
  - in_ready=1, out_valid=0.
  - On each accept, increment exactly one internal counter according to the {GREATER,LESS} decode (10→gt, 01→lt, 00→eq, 11→err).
  - Increment the sample index on every accept. Illegal samples still consume a window slot.
  - If the accept has index==WINDOW-1, on the same edge: load the output registers with the final counts (including this sample), compute majority from them, clear the internal counters and index, and go to HOLD.
- FSM state HOLD:
  - out_valid=1, in_ready=0. in_valid is ignored and no samples are counted.
  - Outputs are stable while out_ready=0.
  - On out_valid & out_ready: go to ACCUM. out_valid drops on the next cycle and outputs retain their last values.
  - A new window may begin accepting on the cycle after the handshake. Back-to-back throughput is WINDOW accept cycles plus 1 handshake cycle per window.
- Latency: out_valid rises on the clock edge that accepts the WINDOW-th sample and is visible the following cycle.
- Counters saturate at 2^CNT_W-1 and never wrap. With WINDOW ≤ 2^CNT_W-1 saturation cannot occur, but it is still implemented.
- majority is combinationally derived from the registered counts at load and registered with them. It never changes while out_valid=1.
- clear=1 (synchronous, highest priority after rst):
  - Zero the internal counters and index; go to ACCUM.
  - out_valid drops next cycle; a held result is discarded without handshake.
  - A sample presented in the same cycle is dropped.
  - Output count registers are not cleared.
- rst asserted mid-window or in HOLD: all state and outputs are zeroed immediately, with no waiting for a clock edge.
- in_valid=1 with X on GREATER/LESS is outside the contract; the bench must not drive it.

Test Plan:
1. Reset: rst=1 for 3 cycles, inputs idle → out_valid=0, all counts 0, majority=00; in_ready=1 after release.
2. WINDOW=4: feed {G,L}=10,01,00,10 on consecutive cycles with out_ready=1 → one cycle after the 4th accept: out_valid=1, gt=2, lt=1, eq=1, err=0, majority=01. out_valid drops next cycle.
3. Backpressure: same window, out_ready=0 for 5 cycles while in_valid=1 with samples 01 → in_ready=0, counts frozen at 2/1/1/0. After out_ready=1 the next window counts only post-handshake samples.
4. Illegal and majority: WINDOW=4, samples 11,01,01,00 → gt=0, lt=2, eq=1, err=1, majority=10. Samples 10,01,00,00 → majority=00.
5. Clear mid-window: accept 10,10, then clear=1 with in_valid=1 and sample 01, then 01,01,01,01 → result lt=4, gt=0, eq=0, majority=10. The cleared-cycle sample is not counted.
6. Async reset in HOLD: pulse rst between clock edges while out_valid=1 → out_valid and counts go to 0 before the next edge. A full sweep of all 4 codes × 64 windows matches a scoreboard.

Source files
------------

// File: rtl/cmp8_window_stats.sv
// cmp8_window_stats
// Classifies each comparator GREATER/LESS sample as greater, less, equal or
// illegal, counts them over a window of WINDOW accepted samples, and presents
// the counts plus a gt-versus-lt majority verdict on a valid/ready output.
module cmp8_window_stats #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             GREATER,
  input  logic             LESS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       majority
);

  // The index is 8 bits wide because WINDOW never exceeds 255.
  localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  logic [7:0]       idx;
  logic [CNT_W-1:0] gt_acc, lt_acc, eq_acc, err_acc;
  logic [CNT_W-1:0] gt_nxt, lt_nxt, eq_nxt, err_nxt;
  logic [1:0]       maj_nxt;
  logic             accept;

  // A counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // Counts including the sample being accepted this cycle. On the last slot
  // of a window these are the values loaded into the outputs, so the final
  // sample is part of the result. The majority verdict is derived from them.
  always_comb begin
    gt_nxt  = gt_acc;
    lt_nxt  = lt_acc;
    eq_nxt  = eq_acc;
    err_nxt = err_acc;
    if (accept) begin
      case ({GREATER, LESS})
        2'b10:   gt_nxt  = sat_inc(gt_acc);
        2'b01:   lt_nxt  = sat_inc(lt_acc);
        2'b00:   eq_nxt  = sat_inc(eq_acc);
        default: err_nxt = sat_inc(err_acc);
      endcase
    end
    if (gt_nxt > lt_nxt)
      maj_nxt = 2'b01;
    else if (lt_nxt > gt_nxt)
      maj_nxt = 2'b10;
    else
      maj_nxt = 2'b00;
  end

  // Window FSM. In ACCUM it collects samples and publishes the result on the
  // last one; in HOLD it keeps the result stable until the consumer takes it.
  // clear abandons the window and any held result, but the published count
  // registers keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      idx      <= '0;
      gt_acc   <= '0;
      lt_acc   <= '0;
      eq_acc   <= '0;
      err_acc  <= '0;
      gt_cnt   <= '0;
      lt_cnt   <= '0;
      eq_cnt   <= '0;
      err_cnt  <= '0;
      majority <= 2'b00;
    end else if (clear) begin
      state   <= ACCUM;
      idx     <= '0;
      gt_acc  <= '0;
      lt_acc  <= '0;
      eq_acc  <= '0;
      err_acc <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              gt_cnt   <= gt_nxt;
              lt_cnt   <= lt_nxt;
              eq_cnt   <= eq_nxt;
              err_cnt  <= err_nxt;
              majority <= maj_nxt;
              gt_acc   <= '0;
              lt_acc   <= '0;
              eq_acc   <= '0;
              err_acc  <= '0;
              idx      <= '0;
              state    <= HOLD;
            end else begin
              gt_acc  <= gt_nxt;
              lt_acc  <= lt_nxt;
              eq_acc  <= eq_nxt;
              err_acc <= err_nxt;
              idx     <= idx + 8'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready)
            state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
